csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_file.sv | 171 +++++++++++++++++
 tb/tb_csr_file.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap/mret state, timer interrupt enable,
// and a free-running 64-bit cycle counter.
module csr_file #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] HART_ID   = '0,
  parameter logic [WIDTH-1:0] MTVEC_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             illegal,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_cause,
  input  logic [WIDTH-1:0] trap_pc,
  input  logic [WIDTH-1:0] trap_val,
  input  logic             mret,
  input  logic             irq_timer,
  output logic             irq_pending,
  output logic [WIDTH-1:0] mtvec,
  output logic [WIDTH-1:0] mepc
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  logic             mie_q, mie_d;
  logic             mpie_q, mpie_d;
  logic             mtie_q, mtie_d;
  logic [WIDTH-1:0] mtvec_q, mtvec_d;
  logic [WIDTH-1:0] mscratch_q, mscratch_d;
  logic [WIDTH-1:0] mepc_q, mepc_d;
  logic [WIDTH-1:0] mcause_q, mcause_d;
  logic [WIDTH-1:0] mtval_q, mtval_d;
  logic [63:0]      mcycle_q, mcycle_d;

  logic             impl;
  logic             ro;
  logic             wr_req;
  logic             csr_we;
  logic [WIDTH-1:0] nv;

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (addr)
      A_MSTATUS: begin
        rdata[3]     = mie_q;
        rdata[7]     = mpie_q;
        rdata[12:11] = 2'b11;
      end
      A_MIE:      rdata[7] = mtie_q;
      A_MTVEC:    rdata = mtvec_q;
      A_MSCRATCH: rdata = mscratch_q;
      A_MEPC:     rdata = mepc_q;
      A_MCAUSE:   rdata = mcause_q;
      A_MTVAL:    rdata = mtval_q;
      A_MIP:      rdata[7] = irq_timer;
      A_MCYCLE:   rdata = mcycle_q[WIDTH-1:0];
      A_MCYCLEH: begin
        if (WIDTH == 32) rdata[31:0] = mcycle_q[63:32];
        else impl = 1'b0;
      end
      A_MHARTID:  rdata = HART_ID;
      default:    impl = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read
  assign ro     = (addr == A_MHARTID) || (addr == A_MIP);
  assign wr_req = (csr_op == 2'b01) ||
                  (csr_op[1] && (wdata != '0));
  assign illegal = (csr_op != 2'b00) &&
                   (!impl || (wr_req && ro));
  assign csr_we = wr_req && !illegal &&
                  !trap_valid && !mret;

  always_comb begin
    case (csr_op)
      2'b01:   nv = wdata;
      2'b10:   nv = rdata | wdata;
      2'b11:   nv = rdata & ~wdata;
      default: nv = rdata;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    if (trap_valid) begin
      mepc_d   = {trap_pc[WIDTH-1:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_val;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (addr)
        A_MSTATUS: begin
          mie_d  = nv[3];
          mpie_d = nv[7];
        end
        A_MIE:      mtie_d = nv[7];
        A_MTVEC:    mtvec_d = {nv[WIDTH-1:2], 2'b00};
        A_MSCRATCH: mscratch_d = nv;
        A_MEPC:     mepc_d = {nv[WIDTH-1:2], 2'b00};
        A_MCAUSE:   mcause_d = nv;
        A_MTVAL:    mtval_d = nv;
        // written half wins; the other half freezes
        A_MCYCLE: begin
          mcycle_d = mcycle_q;
          mcycle_d[WIDTH-1:0] = nv;
        end
        A_MCYCLEH: begin
          mcycle_d = mcycle_q;
          mcycle_d[63:32] = nv[31:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RST[WIDTH-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
    end
  end

  assign irq_pending = mie_q & mtie_q & irq_timer;
  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file (WIDTH=32, HART_ID=5,
// MTVEC_RST=0x1003).
module tb_csr_file;

  logic        clk;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        mret;
  logic        irq_timer;
  logic        irq_pending;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  int checks = 0;
  int errors = 0;

  csr_file #(
    .WIDTH(32),
    .HART_ID(32'd5),
    .MTVEC_RST(32'h0000_1003)
  ) dut (
    .clk(clk),
    .rst(rst),
    .csr_op(csr_op),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .illegal(illegal),
    .trap_valid(trap_valid),
    .trap_cause(trap_cause),
    .trap_pc(trap_pc),
    .trap_val(trap_val),
    .mret(mret),
    .irq_timer(irq_timer),
    .irq_pending(irq_pending),
    .mtvec(mtvec),
    .mepc(mepc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_csr(input string tag,
                         input logic [11:0] a,
                         input logic [31:0] exp);
    csr_op = 2'b00;
    addr   = a;
    #1;
    chk(tag, {32'd0, rdata}, {32'd0, exp});
  endtask

  task automatic wr(input logic [1:0] op,
                    input logic [11:0] a,
                    input logic [31:0] d);
    csr_op = op;
    addr   = a;
    wdata  = d;
    tick();
    csr_op = 2'b00;
    wdata  = '0;
  endtask

  initial begin
    rst        = 1'b1;
    csr_op     = 2'b00;
    addr       = '0;
    wdata      = '0;
    trap_valid = 1'b0;
    trap_cause = '0;
    trap_pc    = '0;
    trap_val   = '0;
    mret       = 1'b0;
    irq_timer  = 1'b0;
    repeat (3) tick();

    chk("rst_mtvec", {32'd0, mtvec}, 64'h1000);
    chk("rst_mepc", {32'd0, mepc}, 64'h0);
    chk_csr("rst_mstatus", 12'h300, 32'h1800);
    chk_csr("rst_mcycle_hold", 12'hB00, 32'h0);
    chk_csr("rst_hartid", 12'hF14, 32'd5);
    rst = 1'b0;
    chk_csr("mcycle_pre", 12'hB00, 32'h0);
    tick();
    chk_csr("mcycle_first", 12'hB00, 32'h1);

    csr_op = 2'b01;
    addr   = 12'h305;
    wdata  = 32'h8000_0103;
    #1;
    chk("mtvec_wr_ill", {63'd0, illegal}, 64'd0);
    tick();
    csr_op = 2'b00;
    chk("mtvec_out", {32'd0, mtvec}, 64'h8000_0100);
    chk_csr("mtvec_rd", 12'h305, 32'h8000_0100);

    wr(2'b01, 12'h300, 32'h0000_0008);
    chk_csr("mstatus_mie", 12'h300, 32'h1808);
    trap_valid = 1'b1;
    trap_pc    = 32'h8000_0046;
    trap_cause = 32'd11;
    trap_val   = 32'h1234;
    tick();
    trap_valid = 1'b0;
    chk("trap_mepc", {32'd0, mepc}, 64'h8000_0044);
    chk_csr("trap_mcause", 12'h342, 32'd11);
    chk_csr("trap_mtval", 12'h343, 32'h1234);
    chk_csr("trap_mstatus", 12'h300, 32'h1880);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk_csr("mret_mstatus", 12'h300, 32'h1888);

    wr(2'b01, 12'h340, 32'h55);
    chk_csr("mscratch_55", 12'h340, 32'h55);
    trap_valid = 1'b1;
    mret       = 1'b1;
    trap_pc    = 32'h0000_0103;
    trap_cause = 32'h8000_0007;
    trap_val   = 32'h0;
    csr_op     = 2'b01;
    addr       = 12'h340;
    wdata      = 32'hAA;
    #1;
    chk("prio_rd_pre", {32'd0, rdata}, 64'h55);
    chk("prio_ill", {63'd0, illegal}, 64'd0);
    tick();
    trap_valid = 1'b0;
    mret       = 1'b0;
    csr_op     = 2'b00;
    chk_csr("prio_mscratch", 12'h340, 32'h55);
    chk_csr("prio_mstatus", 12'h300, 32'h1880);
    chk_csr("prio_mcause", 12'h342, 32'h8000_0007);
    chk("prio_mepc", {32'd0, mepc}, 64'h100);

    csr_op = 2'b01;
    addr   = 12'hF14;
    wdata  = 32'h1;
    #1;
    chk("hart_wr_ill", {63'd0, illegal}, 64'd1);
    chk("hart_wr_rd", {32'd0, rdata}, 64'd5);
    csr_op = 2'b10;
    wdata  = 32'h0;
    #1;
    chk("hart_set0_ill", {63'd0, illegal}, 64'd0);
    csr_op = 2'b11;
    addr   = 12'h344;
    wdata  = 32'h80;
    #1;
    chk("mip_clr_ill", {63'd0, illegal}, 64'd1);
    csr_op = 2'b01;
    addr   = 12'h7C0;
    wdata  = 32'h1;
    #1;
    chk("unimpl_ill", {63'd0, illegal}, 64'd1);
    chk("unimpl_rd", {32'd0, rdata}, 64'd0);
    csr_op = 2'b00;
    #1;
    chk("unimpl_noop_ill", {63'd0, illegal}, 64'd0);

    wr(2'b10, 12'h340, 32'h0F00);
    chk_csr("set_mscratch", 12'h340, 32'h0F55);
    wr(2'b11, 12'h340, 32'h05);
    chk_csr("clr_mscratch", 12'h340, 32'h0F50);
    wr(2'b01, 12'h341, 32'h1234_5677);
    chk("mepc_mask", {32'd0, mepc}, 64'h1234_5674);
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    chk_csr("mie_mask", 12'h304, 32'h80);

    wr(2'b01, 12'hB80, 32'h77);
    chk_csr("mcycleh_wr", 12'hB80, 32'h77);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    chk_csr("mcycle_ff", 12'hB00, 32'hFFFF_FFFF);
    chk_csr("mcycleh_held", 12'hB80, 32'h77);
    tick();
    chk_csr("mcycle_wrap", 12'hB00, 32'h0);
    chk_csr("mcycleh_carry", 12'hB80, 32'h78);
    wr(2'b01, 12'hB00, 32'd5);
    chk_csr("mcycle_5", 12'hB00, 32'd5);
    tick();
    chk_csr("mcycle_6", 12'hB00, 32'd6);
    wr(2'b01, 12'hB00, 32'd10);
    wr(2'b01, 12'hB80, 32'd3);
    chk_csr("mcycleh_3", 12'hB80, 32'd3);
    chk_csr("mcycle_lo_held", 12'hB00, 32'd10);

    irq_timer = 1'b1;
    #1;
    chk("irq_mie0", {63'd0, irq_pending}, 64'd0);
    chk_csr("mip_set", 12'h344, 32'h80);
    irq_timer = 1'b0;
    wr(2'b01, 12'h300, 32'h8);
    chk("irq_low", {63'd0, irq_pending}, 64'd0);
    irq_timer = 1'b1;
    #1;
    chk("irq_high", {63'd0, irq_pending}, 64'd1);
    irq_timer = 1'b0;
    #1;
    chk("irq_drop", {63'd0, irq_pending}, 64'd0);
    irq_timer = 1'b1;

    csr_op = 2'b01;
    addr   = 12'h340;
    wdata  = 32'h99;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_mtvec", {32'd0, mtvec}, 64'h1000);
    chk("mid_mepc", {32'd0, mepc}, 64'h0);
    chk("mid_irq", {63'd0, irq_pending}, 64'd0);
    chk_csr("mid_mstatus", 12'h300, 32'h1800);
    chk_csr("mid_mie", 12'h304, 32'h0);
    chk_csr("mid_mscratch", 12'h340, 32'h0);
    chk_csr("mid_mcause", 12'h342, 32'h0);
    chk_csr("mid_mtval", 12'h343, 32'h0);
    chk_csr("mid_mcycle", 12'hB00, 32'h0);
    chk_csr("mid_mcycleh", 12'hB80, 32'h0);
    csr_op    = 2'b01;
    addr      = 12'h340;
    wdata     = 32'h99;
    irq_timer = 1'b0;
    tick();
    csr_op = 2'b00;
    chk_csr("rst_hold_mscr", 12'h340, 32'h0);
    chk_csr("rst_hold_cyc", 12'hB00, 32'h0);
    rst = 1'b0;
    tick();
    chk_csr("post_rst_cyc", 12'hB00, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
